reg_fifo_drain: RTL

Read-side controller for the team's register FIFO: watches the FIFO's active-low empty flag and issues read enables. It absorbs the FIFO's one-cycle registered read latency in a 3-entry skid buffer. Words are presented downstream as a valid/ready stream with packet framing, sustaining one word per cycle with no combinational path from `out_ready` to `fifo_re`. It sits between the FIFO's `RE`/`EF`/`Q` pins and any streaming consumer.

---
 rtl/reg_fifo_drain_pkg.sv | 31 +++
 rtl/drain_skid_buf.sv | 73 +++++++
 rtl/reg_fifo_drain.sv | 96 +++++++++
 3 files changed

// File: rtl/reg_fifo_drain_pkg.sv
// -----------------------------------------------------------------------------
// reg_fifo_drain_pkg
// Constants shared between the register FIFO and its read-side drain
// controller. This package holds:
//   - the default data width and the FIFO depth/address constants;
//   - the empty-flag polarity;
//   - the skid-buffer geometry, with a pointer-increment helper.
// -----------------------------------------------------------------------------
package reg_fifo_drain_pkg;

  // Data width and FIFO geometry common to the FIFO and the drain block.
  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned FIFO_AW    = $clog2(FIFO_DEPTH);

  // Level of the FIFO EF pin that means "empty" (the flag is active low).
  localparam logic EF_EMPTY_LEVEL = 1'b0;

  // The skid buffer holds 3 words. One is the word being presented, one is
  // the word arriving from the read issued on the previous edge, and one is
  // slack so that the read decision can ignore out_ready.
  localparam int unsigned SKID_DEPTH = 3;

  typedef logic [1:0] skid_ptr_t;   // 0..SKID_DEPTH-1
  typedef logic [1:0] skid_cnt_t;   // 0..SKID_DEPTH

  function automatic skid_ptr_t skid_ptr_inc(input skid_ptr_t p);
    return (p == skid_ptr_t'(SKID_DEPTH - 1)) ? '0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/drain_skid_buf.sv
// -----------------------------------------------------------------------------
// drain_skid_buf
// This is a 3-entry in-order buffer. It catches words returned by the FIFO
// and presents the oldest word at the head.
// Ports:
//   Clock        in   rising-edge clock
//   Reset        in   synchronous, active-high reset
//   i_push       in   write i_push_data into the tail this edge
//   i_push_data  in   word to write
//   i_pop        in   drop the head entry this edge (ignored when empty)
//   o_head       out  head entry contents
//   o_valid      out  buffer holds at least one word
//   o_count      out  number of buffered words (0..3)
// The caller must never push while o_count == 3.
// -----------------------------------------------------------------------------
module drain_skid_buf
  import reg_fifo_drain_pkg::*;
#(
  parameter int unsigned width = DEF_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             i_push,
  input  logic [width-1:0] i_push_data,
  input  logic             i_pop,
  output logic [width-1:0] o_head,
  output logic             o_valid,
  output skid_cnt_t        o_count
);

  logic [width-1:0] r_mem [SKID_DEPTH];
  skid_ptr_t        r_rd_ptr;
  skid_ptr_t        r_wr_ptr;
  skid_cnt_t        r_count;
  logic             w_pop;

  assign w_pop = i_pop & (r_count != '0);

  // NOTE: state registers use non-blocking assignments so that every block
  // sees the pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      // NOTE: the storage is cleared as well, because the head word drives
      // out_data directly and out_data must read 0 while in reset. The array
      // is only three words, so clearing it costs little.
      for (int i = 0; i < SKID_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= skid_ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= skid_ptr_inc(r_rd_ptr);
      end
      // A push and a pop on the same edge leave the occupancy unchanged.
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/reg_fifo_drain.sv
// -----------------------------------------------------------------------------
// reg_fifo_drain
// This is the read-side controller for the register FIFO. It issues reads
// while the FIFO is non-empty and there is room for the result. The
// one-cycle read latency is absorbed in a skid buffer, and the words are
// presented as a framed valid/ready stream.
// Ports:
//   Clock      in   rising-edge clock, shared with the FIFO
//   Reset      in   synchronous, active-high reset
//   enable     in   permits new FIFO reads (words already in flight complete)
//   fifo_ef    in   FIFO empty flag, active low
//   fifo_q     in   FIFO read data, valid the cycle after a read edge
//   fifo_re    out  FIFO read enable
//   out_data   out  head word
//   out_valid  out  head word valid
//   out_last   out  head word is the last of its packet
//   out_ready  in   consumer accepts the head word
//   words_out  out  count of accepted words, wraps modulo 2^cnt_w
// -----------------------------------------------------------------------------
module reg_fifo_drain
  import reg_fifo_drain_pkg::*;
#(
  parameter int unsigned width   = DEF_WIDTH,
  parameter int unsigned pkt_len = 4,
  parameter int unsigned cnt_w   = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             enable,
  input  logic             fifo_ef,
  input  logic [width-1:0] fifo_q,
  output logic             fifo_re,
  output logic [width-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic [cnt_w-1:0] words_out
);

  localparam int unsigned           BEAT_W    = (pkt_len > 1) ? $clog2(pkt_len) : 1;
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(pkt_len - 1);

  logic              r_inflight;
  logic [BEAT_W-1:0] r_beat;
  logic [cnt_w-1:0]  r_words_out;

  skid_cnt_t         w_count;
  logic              w_head_valid;
  logic              w_pop;
  logic              w_not_empty;
  logic              w_room;
  logic              w_fifo_re;

  // A read is issued only when the buffer can hold every word already owed
  // to it. This check does not depend on out_ready, so there is no
  // combinational path from the consumer back to the FIFO.
  assign w_not_empty = (fifo_ef != EF_EMPTY_LEVEL);
  assign w_room      = ({1'b0, w_count} + {2'b00, r_inflight}) < 3'd3;
  assign w_fifo_re   = ~Reset & enable & w_not_empty & w_room;
  assign w_pop       = w_head_valid & out_ready;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      // Clearing r_inflight drops a word that is still in flight, so
      // fifo_q is not pushed on the first edge after reset.
      r_inflight  <= 1'b0;
      r_beat      <= '0;
      r_words_out <= '0;
    end else begin
      r_inflight <= w_fifo_re;
      if (w_pop) begin
        r_words_out <= r_words_out + 1'b1;
        r_beat      <= (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
      end
    end
  end

  drain_skid_buf #(
    .width (width)
  ) u_skid (
    .Clock       (Clock),
    .Reset       (Reset),
    .i_push      (r_inflight),
    .i_push_data (fifo_q),
    .i_pop       (w_pop),
    .o_head      (out_data),
    .o_valid     (w_head_valid),
    .o_count     (w_count)
  );

  assign fifo_re   = w_fifo_re;
  assign out_valid = w_head_valid;
  assign out_last  = w_head_valid & (r_beat == LAST_BEAT);
  assign words_out = r_words_out;

endmodule
